// File: rtl/sar_data_receiver.sv
// SAR ADC half-word receiver: rebuilds 12-bit results from the inverted 6-bit bus into a 2-entry FIFO.
// Result visible 3 edges after the strobe is first low; the FIFO drops (and flags) words when full and not popped.
module sar_data_receiver #(
    parameter int MAX_HIGH = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_z,
    input  logic             clk_data_i,
    input  logic [5:0]       data_i,
    input  logic             single_ended_i,
    output logic [11:0]      res_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             overflow_o,
    output logic             frame_err_o,
    input  logic             err_clr_i,
    output logic [CNT_W-1:0] conv_cnt_o
);

    localparam int HW = $clog2(MAX_HIGH + 1);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HIGH);

    typedef enum logic [1:0] {SYNC, IDLE, CAPTURE} state_t;

    state_t        state_q, state_d;
    logic          strobe_q, strobe_dly_q;
    logic [5:0]    data_q;
    logic [5:0]    upper_q, upper_d, lower_q, lower_d;
    logic          se_q, se_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [11:0]   word_q, word_d;
    logic          word_vld_q, word_vld_d;
    logic          ferr_set;
    logic          rise;

    logic [11:0]   mem_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    fcnt_q;
    logic          full, pop, push, drop;
    logic          ovf_q, ferr_q;
    logic [CNT_W-1:0] conv_cnt_q;

    assign rise = strobe_q & ~strobe_dly_q;

    // Strobe history resets high so a frame in flight at reset release is neither a rise nor a fall.
    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            strobe_q     <= 1'b1;
            strobe_dly_q <= 1'b1;
            data_q       <= '0;
        end else begin
            strobe_q     <= clk_data_i;
            strobe_dly_q <= strobe_q;
            data_q       <= data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        upper_d    = upper_q;
        lower_d    = lower_q;
        se_d       = se_q;
        hcnt_d     = hcnt_q;
        word_d     = word_q;
        word_vld_d = 1'b0;
        ferr_set   = 1'b0;
        case (state_q)
            SYNC: begin
                if (!strobe_q) state_d = IDLE;
            end
            IDLE: begin
                if (rise) begin
                    upper_d = ~data_q;
                    se_d    = single_ended_i;
                    hcnt_d  = HW'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (strobe_q) begin
                    if (hcnt_q == HMAX) begin
                        ferr_set = 1'b1;
                        state_d  = SYNC;
                    end else begin
                        lower_d = ~data_q;
                        hcnt_d  = hcnt_q + HW'(1);
                    end
                end else begin
                    // Strobe was high last cycle in CAPTURE, so a low strobe here is always the fall.
                    state_d = IDLE;
                    if (hcnt_q < HW'(2)) begin
                        ferr_set = 1'b1;
                    end else if (se_q && !upper_q[5]) begin
                        // Single-ended data always carries bit5=1; a zero means a corrupted frame.
                        ferr_set = 1'b1;
                    end else begin
                        word_vld_d = 1'b1;
                        word_d     = {upper_q, lower_q};
                        if (se_q) word_d[11] = 1'b0;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            state_q    <= SYNC;
            upper_q    <= '0;
            lower_q    <= '0;
            se_q       <= 1'b0;
            hcnt_q     <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            upper_q    <= upper_d;
            lower_q    <= lower_d;
            se_q       <= se_d;
            hcnt_q     <= hcnt_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
        end
    end

    assign full = (fcnt_q == 2'd2);
    assign pop  = res_valid_o & res_ready_i;
    assign push = word_vld_q & (~full | pop);
    assign drop = word_vld_q & full & ~pop;

    always_ff @(posedge clk or negedge rst_z) begin
        if (!rst_z) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fcnt_q     <= '0;
            ovf_q      <= 1'b0;
            ferr_q     <= 1'b0;
            conv_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= word_q;
                wr_ptr_q        <= ~wr_ptr_q;
                conv_cnt_q      <= conv_cnt_q + CNT_W'(1);
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 2'd1;
                2'b01:   fcnt_q <= fcnt_q - 2'd1;
                default: fcnt_q <= fcnt_q;
            endcase
            if (drop)           ovf_q <= 1'b1;
            else if (err_clr_i) ovf_q <= 1'b0;
            if (ferr_set)       ferr_q <= 1'b1;
            else if (err_clr_i) ferr_q <= 1'b0;
        end
    end

    assign res_o       = mem_q[rd_ptr_q];
    assign res_valid_o = (fcnt_q != 2'd0);
    assign overflow_o  = ovf_q;
    assign frame_err_o = ferr_q;
    assign conv_cnt_o  = conv_cnt_q;

endmodule

// File: tb/tb_sar_data_receiver.sv
// Directed bench for sar_data_receiver: frame decode, latency, FIFO overflow, framing errors and reset.
module tb_sar_data_receiver;

    logic        clk = 1'b0;
    logic        rst_z;
    logic        clk_data_i;
    logic [5:0]  data_i;
    logic        single_ended_i;
    logic [11:0] res_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic        overflow_o;
    logic        frame_err_o;
    logic        err_clr_i;
    logic [15:0] conv_cnt_o;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [11:0] got_q[$];
    bit          mon_en = 1'b0;
    bit          tog = 1'b0;

    always #5 clk = ~clk;

    sar_data_receiver #(.MAX_HIGH(15), .CNT_W(16)) dut (
        .clk(clk), .rst_z(rst_z), .clk_data_i(clk_data_i), .data_i(data_i),
        .single_ended_i(single_ended_i), .res_o(res_o), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .overflow_o(overflow_o), .frame_err_o(frame_err_o),
        .err_clr_i(err_clr_i), .conv_cnt_o(conv_cnt_o)
    );

    // One clock: log a handshake of the current cycle, step, then optionally toggle ready.
    task automatic cyc();
        if (mon_en && res_valid_o && res_ready_i) got_q.push_back(res_o);
        @(posedge clk);
        #1;
        if (tog) res_ready_i = ~res_ready_i;
    endtask

    task automatic send_frame(input int n, input logic [5:0] first, input logic [5:0] last, input logic se);
        single_ended_i = se;
        for (int i = 0; i < n; i++) begin
            clk_data_i = 1'b1;
            data_i = (i == 0) ? first : ((i == n - 1) ? last : 6'b010101);
            cyc();
        end
        clk_data_i = 1'b0;
        data_i = 6'b0;
        cyc();
    endtask

    task automatic do_reset();
        rst_z = 1'b0; clk_data_i = 1'b0; data_i = '0; single_ended_i = 1'b0;
        res_ready_i = 1'b0; err_clr_i = 1'b0; tog = 1'b0; mon_en = 1'b0;
        cyc(); cyc();
        rst_z = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (res_o !== 12'h000) begin n_fail++; $display("FAIL reset_res: got %h want 000", res_o); end
        n_cmp++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", res_valid_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        n_cmp++; if (conv_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", conv_cnt_o); end
    endtask

    task automatic test_differential();
        do_reset();
        res_ready_i = 1'b1;
        send_frame(8, 6'b101010, 6'b110011, 1'b0);
        cyc();
        n_cmp++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL diff_early_valid: got %b want 0", res_valid_o); end
        cyc();
        n_cmp++; if (res_valid_o !== 1'b1) begin n_fail++; $display("FAIL diff_valid: got %b want 1", res_valid_o); end
        n_cmp++; if (res_o !== 12'h54C) begin n_fail++; $display("FAIL diff_res: got %h want 54c", res_o); end
        n_cmp++; if (conv_cnt_o !== 16'd1) begin n_fail++; $display("FAIL diff_cnt: got %0d want 1", conv_cnt_o); end
        cyc();
        n_cmp++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL diff_popped: got %b want 0", res_valid_o); end
    endtask

    task automatic test_single_ended();
        do_reset();
        res_ready_i = 1'b1;
        send_frame(5, 6'b001111, 6'b000000, 1'b1);
        cyc(); cyc();
        n_cmp++; if (res_valid_o !== 1'b1) begin n_fail++; $display("FAIL se_valid: got %b want 1", res_valid_o); end
        n_cmp++; if (res_o !== 12'h43F) begin n_fail++; $display("FAIL se_res: got %h want 43f", res_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL se_ferr_clean: got %b want 0", frame_err_o); end
        send_frame(5, 6'b101111, 6'b000000, 1'b1);
        cyc(); cyc(); cyc();
        n_cmp++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL se_bit5_ferr: got %b want 1", frame_err_o); end
        n_cmp++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL se_bit5_nopush: got %b want 0", res_valid_o); end
        n_cmp++; if (conv_cnt_o !== 16'd1) begin n_fail++; $display("FAIL se_bit5_cnt: got %0d want 1", conv_cnt_o); end
        single_ended_i = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        send_frame(3, 6'b000001, 6'b000010, 1'b0);
        send_frame(3, 6'b010000, 6'b100000, 1'b0);
        send_frame(3, 6'b000000, 6'b000000, 1'b0);
        cyc(); cyc(); cyc();
        n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow_o); end
        n_cmp++; if (conv_cnt_o !== 16'd2) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 2", conv_cnt_o); end
        n_cmp++; if (res_o !== 12'hFBD) begin n_fail++; $display("FAIL ovf_head0: got %h want fbd", res_o); end
        cyc();
        n_cmp++; if (res_o !== 12'hFBD) begin n_fail++; $display("FAIL ovf_hold: got %h want fbd", res_o); end
        res_ready_i = 1'b1;
        cyc();
        res_ready_i = 1'b0;
        n_cmp++; if (res_o !== 12'hBDF) begin n_fail++; $display("FAIL ovf_head1: got %h want bdf", res_o); end
        n_cmp++; if (res_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovf_valid1: got %b want 1", res_valid_o); end
        err_clr_i = 1'b1;
        cyc();
        err_clr_i = 1'b0;
        n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL ovf_ferr_clear: got %b want 0", frame_err_o); end
    endtask

    task automatic test_frame_errors();
        do_reset();
        res_ready_i = 1'b1;
        send_frame(1, 6'b000111, 6'b000111, 1'b0);
        cyc(); cyc(); cyc();
        n_cmp++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL pulse_ferr: got %b want 1", frame_err_o); end
        n_cmp++; if (conv_cnt_o !== 16'd0) begin n_fail++; $display("FAIL pulse_cnt: got %0d want 0", conv_cnt_o); end
        err_clr_i = 1'b1;
        cyc();
        err_clr_i = 1'b0;
        n_cmp++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL pulse_clear: got %b want 0", frame_err_o); end
        clk_data_i = 1'b1; data_i = 6'b011011;
        repeat (20) cyc();
        n_cmp++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL stuck_ferr: got %b want 1", frame_err_o); end
        n_cmp++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL stuck_nopush: got %b want 0", res_valid_o); end
        clk_data_i = 1'b0; data_i = '0;
        err_clr_i = 1'b1;
        cyc();
        err_clr_i = 1'b0;
        cyc();
        send_frame(15, 6'b000000, 6'b111111, 1'b0);
        cyc(); cyc();
        n_cmp++; if (res_o !== 12'hFC0) begin n_fail++; $display("FAIL max_len_res: got %h want fc0", res_o); end
        n_cmp++; if (conv_cnt_o !== 16'd1) begin n_fail++; $display("FAIL max_len_cnt: got %0d want 1", conv_cnt_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL max_len_ferr: got %b want 0", frame_err_o); end
    endtask

    task automatic test_reset_behaviour();
        rst_z = 1'b0; clk_data_i = 1'b1; data_i = 6'b000011; res_ready_i = 1'b0;
        cyc(); cyc();
        rst_z = 1'b1;
        repeat (5) cyc();
        clk_data_i = 1'b0; data_i = '0;
        repeat (4) cyc();
        n_cmp++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL rel_high_valid: got %b want 0", res_valid_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL rel_high_ferr: got %b want 0", frame_err_o); end
        send_frame(4, 6'b100001, 6'b011110, 1'b0);
        cyc(); cyc();
        n_cmp++; if (res_o !== 12'h7A1) begin n_fail++; $display("FAIL rel_frame_res: got %h want 7a1", res_o); end
        n_cmp++; if (conv_cnt_o !== 16'd1) begin n_fail++; $display("FAIL rel_frame_cnt: got %0d want 1", conv_cnt_o); end
        clk_data_i = 1'b1; data_i = 6'b111000;
        cyc(); cyc(); cyc();
        rst_z = 1'b0;
        #1;
        n_cmp++; if (res_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", res_valid_o); end
        n_cmp++; if (res_o !== 12'h000) begin n_fail++; $display("FAIL mid_rst_res: got %h want 000", res_o); end
        n_cmp++; if (conv_cnt_o !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d want 0", conv_cnt_o); end
        cyc();
        rst_z = 1'b1;
        cyc();
        clk_data_i = 1'b0; data_i = '0;
        cyc(); cyc();
        send_frame(5, 6'b101010, 6'b110011, 1'b0);
        cyc(); cyc();
        n_cmp++; if (res_o !== 12'h54C) begin n_fail++; $display("FAIL post_rst_res: got %h want 54c", res_o); end
        n_cmp++; if (res_valid_o !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid: got %b want 1", res_valid_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        got_q.delete();
        mon_en = 1'b1;
        tog = 1'b1;
        send_frame(4, 6'b000000, 6'b111111, 1'b0);
        send_frame(3, 6'b110110, 6'b001001, 1'b0);
        repeat (12) cyc();
        tog = 1'b0;
        mon_en = 1'b0;
        n_cmp++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            n_cmp++; if (got_q[0] !== 12'hFC0) begin n_fail++; $display("FAIL b2b_word0: got %h want fc0", got_q[0]); end
            n_cmp++; if (got_q[1] !== 12'h276) begin n_fail++; $display("FAIL b2b_word1: got %h want 276", got_q[1]); end
        end
        n_cmp++; if (conv_cnt_o !== 16'd2) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 2", conv_cnt_o); end
        n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", overflow_o); end
    endtask

    initial begin
        test_reset();
        test_differential();
        test_single_ended();
        test_overflow();
        test_frame_errors();
        test_reset_behaviour();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
